// File: rtl/ex_pipe_pkg.sv
// rtl/ex_pipe_pkg.sv - shared codes, state encoding and payload width for the EX/MEM pipeline register
package ex_pipe_pkg;

  localparam int EXP_NO_EXP   = 0;
  localparam int EXP_EXT_INT  = 1;
  localparam int EXP_OVERFLOW = 2;

  localparam int MEM_OP_NOP  = 0;
  localparam int CTRL_OP_NOP = 0;

  // Bit 0 doubles as "main entry valid", bit 1 as "skid entry valid".
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_e;

  function automatic int payload_w(input int addr_w, input int data_w, input int mem_op_w,
                                   input int ctrl_op_w, input int reg_addr_w, input int exp_w);
    return addr_w + 1 + mem_op_w + data_w + ctrl_op_w + reg_addr_w + 1 + exp_w + data_w;
  endfunction

endpackage

// File: rtl/ex_pipe_entry.sv
// rtl/ex_pipe_entry.sv - one payload register slot with synchronous load, clear and reset
module ex_pipe_entry
  import ex_pipe_pkg::*;
#(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!reset || i_clear) begin
      r_q <= RST_VAL;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ex_pipe_reg.sv
// rtl/ex_pipe_reg.sv - 2-entry elastic EX/MEM register; EX_PIPE_REG_STALL_CNT_EN adds a backpressure counter
module ex_pipe_reg
  import ex_pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 30,
  parameter int MEM_OP_W   = 2,
  parameter int CTRL_OP_W  = 2,
  parameter int REG_ADDR_W = 5,
  parameter int EXP_W      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     alu_out,
  input  logic                  alu_of,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  int_detect,
  input  logic                  id_en,
  input  logic [ADDR_W-1:0]     id_pc,
  input  logic                  id_br_flag,
  input  logic [MEM_OP_W-1:0]   id_mem_op,
  input  logic [DATA_W-1:0]     id_mem_wr_data,
  input  logic [CTRL_OP_W-1:0]  id_ctrl_op,
  input  logic [REG_ADDR_W-1:0] id_dst_addr,
  input  logic                  id_gpr_we_,
  input  logic [EXP_W-1:0]      id_exp_code,
  input  logic                  mem_ready,
  output logic                  ex_ready,
  output logic                  ex_en,
  output logic [ADDR_W-1:0]     ex_pc,
  output logic                  ex_br_flag,
  output logic [MEM_OP_W-1:0]   ex_mem_op,
  output logic [DATA_W-1:0]     ex_mem_wr_data,
  output logic [CTRL_OP_W-1:0]  ex_ctrl_op,
  output logic [REG_ADDR_W-1:0] ex_dst_addr,
  output logic                  ex_gpr_we_,
  output logic [EXP_W-1:0]      ex_exp_code,
  output logic [DATA_W-1:0]     ex_out,
  output logic [31:0]           ex_stall_cnt
);

  localparam int PW = payload_w(ADDR_W, DATA_W, MEM_OP_W, CTRL_OP_W, REG_ADDR_W, EXP_W);

  localparam logic [PW-1:0] RST_PAYLOAD = {
    ADDR_W'(0), 1'b0, MEM_OP_W'(MEM_OP_NOP), DATA_W'(0), CTRL_OP_W'(CTRL_OP_NOP),
    REG_ADDR_W'(0), 1'b1, EXP_W'(EXP_NO_EXP), DATA_W'(0)
  };

  state_e        r_state;
  state_e        w_next;
  logic          r_ready;
  logic          w_accept;
  logic          w_drain;
  logic          w_exc;
  logic          w_main_load;
  logic          w_main_from_skid;
  logic          w_skid_load;
  logic [PW-1:0] w_new;
  logic [PW-1:0] w_main_d;
  logic [PW-1:0] w_main_q;
  logic [PW-1:0] w_skid_q;

  assign ex_en    = (r_state != EMPTY);
  assign ex_ready = r_ready;
  assign w_accept = id_en & r_ready & ~stall & ~flush;
  assign w_drain  = ex_en & mem_ready;

  // Interrupt or overflow squashes every side effect but keeps pc/br_flag for the handler.
  assign w_exc = int_detect | alu_of;
  assign w_new = {
    id_pc,
    id_br_flag,
    w_exc ? MEM_OP_W'(MEM_OP_NOP) : id_mem_op,
    w_exc ? {DATA_W{1'b0}} : id_mem_wr_data,
    w_exc ? CTRL_OP_W'(CTRL_OP_NOP) : id_ctrl_op,
    w_exc ? {REG_ADDR_W{1'b0}} : id_dst_addr,
    w_exc ? 1'b1 : id_gpr_we_,
    int_detect ? EXP_W'(EXP_EXT_INT) : (alu_of ? EXP_W'(EXP_OVERFLOW) : id_exp_code),
    w_exc ? {DATA_W{1'b0}} : alu_out
  };

  always_comb begin
    w_next           = r_state;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    if (flush) begin
      w_next = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_next      = ONE;
            w_main_load = 1'b1;
          end
        end
        ONE: begin
          if (w_accept && w_drain) begin
            w_main_load = 1'b1;
          end else if (w_accept) begin
            w_next      = TWO;
            w_skid_load = 1'b1;
          end else if (w_drain) begin
            w_next = EMPTY;
          end
        end
        TWO: begin
          if (w_drain) begin
            w_next           = ONE;
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
          end
        end
        default: w_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= EMPTY;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next != TWO);
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : w_new;

  ex_pipe_entry #(.W(PW), .RST_VAL(RST_PAYLOAD)) u_main (
    .clk(clk), .reset(reset), .i_load(w_main_load), .i_clear(flush), .i_d(w_main_d), .o_q(w_main_q)
  );

  ex_pipe_entry #(.W(PW), .RST_VAL(RST_PAYLOAD)) u_skid (
    .clk(clk), .reset(reset), .i_load(w_skid_load), .i_clear(flush), .i_d(w_new), .o_q(w_skid_q)
  );

  assign {ex_pc, ex_br_flag, ex_mem_op, ex_mem_wr_data, ex_ctrl_op,
          ex_dst_addr, ex_gpr_we_, ex_exp_code, ex_out} = w_main_q;

`ifdef EX_PIPE_REG_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Survives flush so software can read cumulative MEM backpressure.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (ex_en && !mem_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign ex_stall_cnt = r_stall_cnt;
`else
  assign ex_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ex_pipe_reg.sv
// tb/tb_ex_pipe_reg.sv - directed self-checking bench for ex_pipe_reg
module tb_ex_pipe_reg;

`ifdef EX_PIPE_REG_STALL_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_out;
  logic        alu_of, stall, flush, int_detect, id_en, mem_ready;
  logic [29:0] id_pc;
  logic        id_br_flag, id_gpr_we_;
  logic [1:0]  id_mem_op, id_ctrl_op;
  logic [31:0] id_mem_wr_data;
  logic [4:0]  id_dst_addr;
  logic [2:0]  id_exp_code;
  logic        ex_ready, ex_en, ex_br_flag, ex_gpr_we_;
  logic [29:0] ex_pc;
  logic [1:0]  ex_mem_op, ex_ctrl_op;
  logic [31:0] ex_mem_wr_data, ex_out, ex_stall_cnt;
  logic [4:0]  ex_dst_addr;
  logic [2:0]  ex_exp_code;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_pipe_reg dut (
    .clk(clk), .reset(reset), .alu_out(alu_out), .alu_of(alu_of), .stall(stall), .flush(flush),
    .int_detect(int_detect), .id_en(id_en), .id_pc(id_pc), .id_br_flag(id_br_flag),
    .id_mem_op(id_mem_op), .id_mem_wr_data(id_mem_wr_data), .id_ctrl_op(id_ctrl_op),
    .id_dst_addr(id_dst_addr), .id_gpr_we_(id_gpr_we_), .id_exp_code(id_exp_code),
    .mem_ready(mem_ready), .ex_ready(ex_ready), .ex_en(ex_en), .ex_pc(ex_pc),
    .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op), .ex_mem_wr_data(ex_mem_wr_data),
    .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr), .ex_gpr_we_(ex_gpr_we_),
    .ex_exp_code(ex_exp_code), .ex_out(ex_out), .ex_stall_cnt(ex_stall_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_out = 0; alu_of = 0; stall = 0; flush = 0; int_detect = 0; id_en = 0; mem_ready = 1;
    id_pc = 0; id_br_flag = 0; id_mem_op = 0; id_mem_wr_data = 0; id_ctrl_op = 0;
    id_dst_addr = 0; id_gpr_we_ = 1; id_exp_code = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0; id_en = 1; id_pc = 30'h3F; alu_out = 32'h77; id_gpr_we_ = 0; mem_ready = 0;
    step(); step();
    n_vec++; if (ex_en !== 1'b0) begin n_err++; $display("FAIL rst_en got %b exp 0", ex_en); end
    n_vec++; if (ex_gpr_we_ !== 1'b1) begin n_err++; $display("FAIL rst_we got %b exp 1", ex_gpr_we_); end
    n_vec++; if (ex_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b exp 1", ex_ready); end
    n_vec++; if (ex_exp_code !== 3'd0) begin n_err++; $display("FAIL rst_exp got %0d exp 0", ex_exp_code); end
    n_vec++; if (ex_stall_cnt !== 32'd0) begin n_err++; $display("FAIL rst_cnt got %0d exp 0", ex_stall_cnt); end
    n_vec++; if (ex_pc !== 30'd0 || ex_out !== 32'd0) begin n_err++; $display("FAIL rst_payload got pc %h out %h exp 0 0", ex_pc, ex_out); end
    idle_inputs();
    reset = 1;
    step();
    n_vec++; if (ex_en !== 1'b0) begin n_err++; $display("FAIL rst_idle_en got %b exp 0", ex_en); end
  endtask

  task automatic test_streaming();
    logic [29:0] pc;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      pc = 30'h10 + 30'(i);
      id_en = 1; id_pc = pc; alu_out = {2'b00, pc} * 2;
      step();
      n_vec++; if (ex_en !== 1'b1 || ex_pc !== pc) begin n_err++; $display("FAIL stream_pc%0d got en %b pc %h exp 1 %h", i, ex_en, ex_pc, pc); end
      n_vec++; if (ex_out !== 32'h20 + 32'(2 * i)) begin n_err++; $display("FAIL stream_out%0d got %h exp %h", i, ex_out, 32'h20 + 32'(2 * i)); end
      n_vec++; if (ex_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready%0d got %b exp 1", i, ex_ready); end
    end
    id_en = 0;
    step();
    n_vec++; if (ex_en !== 1'b0) begin n_err++; $display("FAIL stream_drain got en %b exp 0", ex_en); end
  endtask

  task automatic test_backpressure();
    idle_inputs();
    mem_ready = 0;
    id_en = 1; id_pc = 30'h20; alu_out = 32'h40;
    step();
    n_vec++; if (ex_pc !== 30'h20 || ex_ready !== 1'b1) begin n_err++; $display("FAIL bp_first got pc %h rdy %b exp 20 1", ex_pc, ex_ready); end
    id_pc = 30'h21; alu_out = 32'h42;
    step();
    n_vec++; if (ex_pc !== 30'h20 || ex_ready !== 1'b0) begin n_err++; $display("FAIL bp_full got pc %h rdy %b exp 20 0", ex_pc, ex_ready); end
    id_pc = 30'h22; alu_out = 32'h44;
    step(); step();
    n_vec++; if (ex_pc !== 30'h20 || ex_out !== 32'h40 || ex_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold got pc %h out %h rdy %b exp 20 40 0", ex_pc, ex_out, ex_ready); end
    n_vec++; if (ex_stall_cnt !== (CNT_ON ? 32'd3 : 32'd0)) begin n_err++; $display("FAIL bp_cnt got %0d exp %0d", ex_stall_cnt, CNT_ON ? 3 : 0); end
    mem_ready = 1;
    step();
    n_vec++; if (ex_en !== 1'b1 || ex_pc !== 30'h21 || ex_out !== 32'h42 || ex_ready !== 1'b1) begin n_err++; $display("FAIL bp_second got pc %h out %h rdy %b exp 21 42 1", ex_pc, ex_out, ex_ready); end
    step();
    n_vec++; if (ex_en !== 1'b1 || ex_pc !== 30'h22 || ex_out !== 32'h44) begin n_err++; $display("FAIL bp_third got pc %h out %h exp 22 44", ex_pc, ex_out); end
    id_en = 0;
    step();
    n_vec++; if (ex_en !== 1'b0) begin n_err++; $display("FAIL bp_empty got en %b exp 0", ex_en); end
    n_vec++; if (ex_stall_cnt !== (CNT_ON ? 32'd3 : 32'd0)) begin n_err++; $display("FAIL bp_cnt_after got %0d exp %0d", ex_stall_cnt, CNT_ON ? 3 : 0); end
  endtask

  task automatic test_exceptions();
    idle_inputs();
    id_en = 1; id_pc = 30'h30; id_br_flag = 1; alu_of = 1; id_mem_op = 2'd2; id_gpr_we_ = 0;
    id_mem_wr_data = 32'hDEAD; id_ctrl_op = 2'd1; id_dst_addr = 5'd5; alu_out = 32'h1234;
    step();
    n_vec++; if (ex_pc !== 30'h30 || ex_br_flag !== 1'b1) begin n_err++; $display("FAIL ov_pass got pc %h br %b exp 30 1", ex_pc, ex_br_flag); end
    n_vec++; if (ex_mem_op !== 2'd0 || ex_gpr_we_ !== 1'b1 || ex_ctrl_op !== 2'd0 || ex_dst_addr !== 5'd0) begin n_err++; $display("FAIL ov_mask got mop %0d we %b cop %0d dst %0d exp 0 1 0 0", ex_mem_op, ex_gpr_we_, ex_ctrl_op, ex_dst_addr); end
    n_vec++; if (ex_exp_code !== 3'd2 || ex_out !== 32'd0 || ex_mem_wr_data !== 32'd0) begin n_err++; $display("FAIL ov_exp got exp %0d out %h wd %h exp 2 0 0", ex_exp_code, ex_out, ex_mem_wr_data); end
    int_detect = 1; id_pc = 30'h31;
    step();
    n_vec++; if (ex_pc !== 30'h31 || ex_exp_code !== 3'd1 || ex_gpr_we_ !== 1'b1) begin n_err++; $display("FAIL int_prio got pc %h exp %0d we %b exp 31 1 1", ex_pc, ex_exp_code, ex_gpr_we_); end
    int_detect = 0; alu_of = 0; id_pc = 30'h32; id_br_flag = 0; id_mem_wr_data = 32'hBEEF;
    id_ctrl_op = 2'd3; id_dst_addr = 5'd7; id_exp_code = 3'd4; alu_out = 32'h5555;
    step();
    n_vec++; if (ex_mem_op !== 2'd2 || ex_gpr_we_ !== 1'b0 || ex_mem_wr_data !== 32'hBEEF || ex_ctrl_op !== 2'd3) begin n_err++; $display("FAIL pass_ctl got mop %0d we %b wd %h cop %0d exp 2 0 beef 3", ex_mem_op, ex_gpr_we_, ex_mem_wr_data, ex_ctrl_op); end
    n_vec++; if (ex_dst_addr !== 5'd7 || ex_exp_code !== 3'd4 || ex_out !== 32'h5555 || ex_pc !== 30'h32) begin n_err++; $display("FAIL pass_data got dst %0d exp %0d out %h pc %h exp 7 4 5555 32", ex_dst_addr, ex_exp_code, ex_out, ex_pc); end
    id_en = 0; int_detect = 1; alu_of = 1;
    step();
    n_vec++; if (ex_en !== 1'b0) begin n_err++; $display("FAIL exc_noaccept got en %b exp 0", ex_en); end
  endtask

  task automatic test_flush();
    idle_inputs();
    mem_ready = 0;
    id_en = 1; id_pc = 30'h40; alu_out = 32'h80; id_gpr_we_ = 0; id_mem_op = 2'd1;
    step();
    id_pc = 30'h41; alu_out = 32'h82;
    step();
    n_vec++; if (ex_ready !== 1'b0 || ex_pc !== 30'h40) begin n_err++; $display("FAIL fl_full got rdy %b pc %h exp 0 40", ex_ready, ex_pc); end
    stall = 1; id_pc = 30'h42;
    step();
    flush = 1;
    step();
    n_vec++; if (ex_en !== 1'b0 || ex_ready !== 1'b1) begin n_err++; $display("FAIL fl_state got en %b rdy %b exp 0 1", ex_en, ex_ready); end
    n_vec++; if (ex_pc !== 30'd0 || ex_out !== 32'd0 || ex_gpr_we_ !== 1'b1 || ex_mem_op !== 2'd0 || ex_exp_code !== 3'd0) begin n_err++; $display("FAIL fl_payload got pc %h out %h we %b mop %0d exp %0d exp 0 0 1 0 0", ex_pc, ex_out, ex_gpr_we_, ex_mem_op, ex_exp_code); end
    flush = 0; stall = 0; id_en = 0; mem_ready = 1;
    step();
    n_vec++; if (ex_en !== 1'b0 || ex_pc !== 30'd0) begin n_err++; $display("FAIL fl_noskid got en %b pc %h exp 0 0", ex_en, ex_pc); end
    n_vec++; if (ex_stall_cnt !== (CNT_ON ? 32'd6 : 32'd0)) begin n_err++; $display("FAIL fl_cnt got %0d exp %0d", ex_stall_cnt, CNT_ON ? 6 : 0); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_exceptions();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
